// File: rtl/transposer_arbiter.sv
// transposer_arbiter
//   Lets NREQ requesters (attention/matmul engines) take turns on a single
//   transposer. Picks the next owner round-robin, runs the transposer's
//   load/compute/deliver handshake, drives the select for the input mux, and
//   routes the completion and acceptance signals for each requester.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   req[NREQ]         job request per requester, held until its taken pulse
//   taken[NREQ]       requester accepted the transposed result
//   gnt[NREQ]         one-hot; owner drives the transposer input this cycle
//   done_vld[NREQ]    one-hot; owner's result is valid on the transposer output
//   sel[IDXW]         input mux select, equal to the current owner
//   busy              FSM is not in IDLE
//   tr_state[2]       transposer state: 00 idle, 01 compute, 10 done, 11 illegal
//   tr_input_ready    load strobe to the transposer
//   tr_output_taken   release strobe to the transposer
//   job_cnt           per-requester count of completed jobs (optional, saturating)
//
// Optional feature: define TRANSPOSER_ARB_STATS_EN to add the job_cnt output.
module transposer_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDXW  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      taken,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done_vld,
    output logic [IDXW-1:0]      sel,
    output logic                 busy,
    input  logic [1:0]           tr_state,
    output logic                 tr_input_ready,
    output logic                 tr_output_taken
`ifdef TRANSPOSER_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][CNT_W-1:0] job_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    if (NREQ < 2) begin : g_nreq_check
        $error("NREQ must be at least 2");
    end

    state_t          state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] last_q,  last_d;

    logic            found;
    logic [IDXW-1:0] winner;
    logic [IDXW:0]   cand;
    logic            legal;

    // tr_state 11 is treated as illegal and freezes every transition.
    assign legal = (tr_state != 2'b11);

    // Round-robin scan starting just after the last served requester, so the
    // requester served most recently is looked at last.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        cand   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last_q} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(NREQ)) begin
                cand = cand - (IDXW+1)'(NREQ);
            end
            if (!found && req[cand[IDXW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDXW-1:0];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_d          = last_q;
        gnt             = '0;
        done_vld        = '0;
        tr_input_ready  = 1'b0;
        tr_output_taken = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && tr_state == 2'b00) begin
                    owner_d = winner;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                gnt[owner_q]   = 1'b1;
                tr_input_ready = 1'b1;
                if (legal) state_d = WAIT;
            end
            WAIT: begin
                if (tr_state == 2'b10) state_d = DELIVER;
            end
            DELIVER: begin
                if (!req[owner_q]) begin
                    // Owner walked away: release the transposer ourselves and
                    // discard the result without touching the rotation.
                    tr_output_taken = 1'b1;
                    if (legal) state_d = IDLE;
                end else begin
                    done_vld[owner_q] = 1'b1;
                    tr_output_taken   = taken[owner_q];
                    if (taken[owner_q] && legal) begin
                        last_d  = owner_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDXW'(NREQ-1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign sel  = owner_q;

`ifdef TRANSPOSER_ARB_STATS_EN
    logic                        complete;
    logic [NREQ-1:0][CNT_W-1:0]  cnt_q;

    assign complete = (state_q == DELIVER) && req[owner_q] && taken[owner_q] && legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (complete && cnt_q[owner_q] != '1) begin
            cnt_q[owner_q] <= cnt_q[owner_q] + CNT_W'(1);
        end
    end

    assign job_cnt = cnt_q;
`else
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_transposer_arbiter.sv
// tb_transposer_arbiter
//   Directed bench for transposer_arbiter with NREQ=4. The bench plays the
//   transposer itself by driving tr_state by hand, and checks grant order,
//   latency, owner drop, busy-transposer stall, illegal-state hold and reset.
module tb_transposer_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] taken;
    logic [3:0] gnt;
    logic [3:0] done_vld;
    logic [1:0] sel;
    logic       busy;
    logic [1:0] tr_state;
    logic       tr_input_ready;
    logic       tr_output_taken;
`ifdef TRANSPOSER_ARB_STATS_EN
    logic [3:0][1:0] job_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef TRANSPOSER_ARB_STATS_EN
    transposer_arbiter #(.NREQ(4), .IDXW(2), .CNT_W(2)) dut (
`else
    transposer_arbiter #(.NREQ(4), .IDXW(2)) dut (
`endif
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .taken           (taken),
        .gnt             (gnt),
        .done_vld        (done_vld),
        .sel             (sel),
        .busy            (busy),
        .tr_state        (tr_state),
        .tr_input_ready  (tr_input_ready),
        .tr_output_taken (tr_output_taken)
`ifdef TRANSPOSER_ARB_STATS_EN
        ,
        .job_cnt         (job_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        req      = '0;
        taken    = '0;
        tr_state = 2'b00;
        step();
        step();
        reset = 1'b0;
    endtask

    // One full job for the expected owner; req stays at reqv afterwards.
    task automatic do_job(input int owner, input logic [3:0] reqv, input bit noise);
        logic [3:0] oh;
        bit         got_gnt;
        oh      = 4'b0001 << owner;
        got_gnt = 1'b0;
        req     = reqv;
        for (int n = 0; n < 8 && !got_gnt; n++) begin
            step();
            if (gnt != 4'b0000) got_gnt = 1'b1;
        end
        if (!got_gnt) begin
            check("gnt_timeout", 32'd0, 32'd1);
            return;
        end
        check("job_gnt", 32'(gnt), 32'(oh));
        check("job_sel", 32'(sel), 32'(owner));
        check("job_load", 32'(tr_input_ready), 32'd1);
        step();
        tr_state = 2'b01;
        step();
        tr_state = 2'b10;
        step();
        #1;
        check("job_done", 32'(done_vld), 32'(oh));
        check("job_sel_hold", 32'(sel), 32'(owner));
        check("job_tot_idle", 32'(tr_output_taken), 32'd0);
        if (noise) begin
            taken = ~oh;
            #1;
            check("nonowner_taken", 32'(tr_output_taken), 32'd0);
            step();
            check("nonowner_hold", 32'(done_vld), 32'(oh));
        end
        taken = oh;
        #1;
        check("job_tot", 32'(tr_output_taken), 32'd1);
        step();
        taken    = '0;
        tr_state = 2'b00;
        check("job_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        do_reset();
        reset = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done_vld), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // Single job with exact cycle timing.
        req = 4'b0001;
        #1;
        check("c0_gnt", 32'(gnt), 32'd0);
        step();
        check("c1_gnt", 32'(gnt), 32'b0001);
        check("c1_load", 32'(tr_input_ready), 32'd1);
        check("c1_busy", 32'(busy), 32'd1);
        step();
        check("c2_gnt", 32'(gnt), 32'd0);
        check("c2_load", 32'(tr_input_ready), 32'd0);
        tr_state = 2'b01;
        step();
        tr_state = 2'b10;
        check("c3_done", 32'(done_vld), 32'd0);
        step();
        check("c4_done", 32'(done_vld), 32'b0001);
        check("c4_tot", 32'(tr_output_taken), 32'd0);
        taken = 4'b0001;
        #1;
        check("c4_tot_taken", 32'(tr_output_taken), 32'd1);
        step();
        taken    = '0;
        req      = '0;
        tr_state = 2'b00;
        check("c5_busy", 32'(busy), 32'd0);

        // Round-robin from reset: 0,1,2,3,0.
        do_reset();
        do_job(0, 4'b1111, 1'b0);
        do_job(1, 4'b1111, 1'b0);
        do_job(2, 4'b1111, 1'b0);
        do_job(3, 4'b1111, 1'b0);
        do_job(0, 4'b1111, 1'b0);

        // Wrap-around: bring last to 3, then 1001 -> 0, then 1001 -> 3.
        do_reset();
        do_job(0, 4'b1111, 1'b0);
        do_job(1, 4'b1111, 1'b0);
        do_job(2, 4'b1111, 1'b0);
        do_job(3, 4'b1111, 1'b0);
        do_job(0, 4'b1001, 1'b1);
        do_job(3, 4'b1001, 1'b0);
        req = '0;
        step();

        // Owner drop in DELIVER.
        req = 4'b0100;
        step();
        check("drop_gnt", 32'(gnt), 32'b0100);
        step();
        tr_state = 2'b01;
        step();
        tr_state = 2'b10;
        step();
        check("drop_done_pre", 32'(done_vld), 32'b0100);
        req = 4'b0000;
        #1;
        check("drop_done", 32'(done_vld), 32'd0);
        check("drop_tot", 32'(tr_output_taken), 32'd1);
        check("drop_busy", 32'(busy), 32'd1);
        step();
        tr_state = 2'b00;
        #1;
        check("drop_idle", 32'(busy), 32'd0);
        check("drop_tot_off", 32'(tr_output_taken), 32'd0);

        // Busy transposer blocks the grant.
        tr_state = 2'b01;
        req      = 4'b0010;
        for (int n = 0; n < 3; n++) begin
            step();
            check("stall_gnt", 32'(gnt), 32'd0);
            check("stall_busy", 32'(busy), 32'd0);
        end
        tr_state = 2'b00;
        step();
        check("unstall_gnt", 32'(gnt), 32'b0010);
        check("unstall_sel", 32'(sel), 32'd1);
        step();
        // Illegal tr_state holds WAIT.
        tr_state = 2'b11;
        step();
        step();
        check("hold11_busy", 32'(busy), 32'd1);
        check("hold11_done", 32'(done_vld), 32'd0);
        check("hold11_gnt", 32'(gnt), 32'd0);
        // Reset while in WAIT.
        tr_state = 2'b01;
        reset    = 1'b1;
        step();
        check("rstw_gnt", 32'(gnt), 32'd0);
        check("rstw_done", 32'(done_vld), 32'd0);
        check("rstw_sel", 32'(sel), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_load", 32'(tr_input_ready), 32'd0);
        check("rstw_tot", 32'(tr_output_taken), 32'd0);
        reset    = 1'b0;
        req      = '0;
        tr_state = 2'b00;
        step();
        do_job(0, 4'b0001, 1'b0);
        req = '0;
        step();

`ifdef TRANSPOSER_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 5; k++) do_job(1, 4'b0010, 1'b0);
        req = '0;
        step();
        check("stats_cnt1", 32'(job_cnt[1]), 32'd3);
        check("stats_cnt0", 32'(job_cnt[0]), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
